wb_master_arbiter: RTL
======================

Name: wb_master_arbiter

Overview:
- Round-robin arbiter/sequencer that shares one wb_master_interface (single-transfer Wishbone master) between NUM_REQ local requesters.
- Latches the winning request, pulses the master's start, tracks the transfer through ack/err, returns read data and a completion pulse to the winner.
- Sits between on-chip agents (DMA, debug, test engines) and the wb_master_interface instance.

Parameters:
NUM_REQ, 4, number of requesters (legal 2..8)
dw, 32, data width
aw, 32, address width

Ports:
wb_clk  in  1  system clock
wb_rst_n  in  1  asynchronous active-low reset
req  in  NUM_REQ  per-requester request, level, held until done/err
req_addr  in  NUM_REQ*aw  packed addresses, requester i at [i*aw +: aw]
req_sel  in  NUM_REQ*4  packed byte selects
req_we  in  NUM_REQ  1=write, 0=read
req_wdata  in  NUM_REQ*dw  packed write data
gnt  out  NUM_REQ  one-hot grant, held for the whole transaction
done  out  NUM_REQ  one-cycle success pulse to granted requester
err  out  NUM_REQ  one-cycle error/retry pulse to granted requester
rdata  out  dw  registered read data, valid from the done pulse until the next read completes
m_start  out  1  start pulse to master
m_address  out  aw  to master address
m_selection  out  4  to master selection
m_write  out  1  to master write
m_data_wr  out  dw  to master data_wr
m_data_rd  in  dw  master data_rd (valid in ack cycle)
m_active  in  1  master active
m_ack  in  1  tap of wb_ack_i
m_err  in  1  tap of wb_err_i | wb_rty_i

Behaviour:
- Clocking/reset: one clock wb_clk; reset wb_rst_n is asynchronous and active-low. All outputs are registered.
- Reset values: all outputs 0; state IDLE; RR pointer = NUM_REQ-1, so requester 0 wins first.
- FSM states: IDLE, START, BUSY, DRAIN.
- IDLE: if any req bit is set, pick a winner by round-robin, searching from pointer+1 with wrap. Register gnt one-hot, latch m_address/m_selection/m_write/m_data_wr from the winner's slice, update pointer to winner, go to START. If no req, stay in IDLE.
- START: m_start=1 for exactly this one cycle; go to BUSY.
- BUSY: m_start=0. m_address/m_selection/m_write/m_data_wr stay stable for the whole transaction.
  - m_err=1: err[g] pulses next cycle; go to DRAIN.
  - else m_ack=1: done[g] pulses next cycle; if !m_write, rdata<=m_data_rd in the same edge; go to DRAIN.
  - else stay in BUSY. No timeout.
- Simultaneous ack and err: err wins; done is not pulsed and rdata is not updated.
- DRAIN: wait for m_active==0 (minimum 1 cycle), clear gnt, go to IDLE.
- Latency, request sampled at cycle 0 with a zero-wait slave:
  - gnt/m_start at cycle 1;
  - slave ack at cycle 2;
  - done at cycle 3;
  - IDLE at cycle 4;
  - next gnt at cycle 5.
- Dropping req while granted does not abort the transfer; done/err are still pulsed.
- New req bits arriving during a transaction are considered only on return to IDLE.
- Reset mid-operation: immediate return to reset values, with no done/err pulse. The master interface is reset by the same system reset.
- gnt, done and err are always one-hot or zero.

Optional Feature:
- Macro: WB_ARB_FIXED_PRIO_EN.
- When defined: fixed priority, lowest index wins. The pointer is unused.
- When undefined: round-robin as above.

Test Plan:
- Single read: req=0001, addr0=0x100, slave returns 0xDEADBEEF with ack at cycle 2 -> m_start pulses 1 cycle with m_address=0x100 and m_write=0; done=0001 at cycle 3; rdata=0xDEADBEEF.
- Round-robin fairness: req=1111 held for 8 transactions -> grant order 0,1,2,3,0,1,2,3, each with exactly one done pulse. With WB_ARB_FIXED_PRIO_EN the grant order is 0 every time.
- Write with wait states: req=0100, we=1, wdata=0x12345678, ack delayed 5 cycles -> m_* fields stable throughout BUSY; done=0100 once; rdata unchanged.
- Error/retry: m_err asserted in the ack cycle (also once together with m_ack) -> err pulses for the granted requester; no done; rdata unchanged; next grant is issued only after m_active falls.
- Reset mid-transfer: deassert wb_rst_n while in BUSY -> all outputs 0 immediately. After release, req=1000|0001 grants requester 0 first.
- Late request: req1 asserted while requester 2 is in BUSY -> req1 is granted only after requester 2's DRAIN completes; no overlap of gnt bits.

Source files
------------

// File: rtl/wb_master_arbiter.sv
// wb_master_arbiter
//   Shares one single-transfer Wishbone master between NUM_REQ local
//   requesters. A winner is picked in IDLE (round-robin by default), its
//   request fields are latched onto the m_* bus, m_start is pulsed once, and
//   the transfer is tracked until ack/err. The winner then gets a one-cycle
//   done or err pulse, and reads also load rdata. The grant is released once
//   the master reports inactive.
//
//   Build option: define WB_ARB_FIXED_PRIO_EN to use fixed priority, where the
//   lowest index wins and no round-robin pointer exists.
//
// Ports
//   wb_clk, wb_rst_n        clock, asynchronous active-low reset
//   req / req_addr / req_sel / req_we / req_wdata
//                           per-requester request level and packed fields
//                           (requester i occupies slice i of each bus)
//   gnt                     one-hot grant, held for the whole transaction
//   done / err              one-cycle completion / error pulse to the winner
//   rdata                   read data of the last successful read
//   m_start, m_address, m_selection, m_write, m_data_wr
//                           command side of the shared master
//   m_data_rd, m_active, m_ack, m_err
//                           status side of the shared master
module wb_master_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int dw      = 32,
  parameter int aw      = 32
) (
  input  logic                 wb_clk,
  input  logic                 wb_rst_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ*aw-1:0] req_addr,
  input  logic [NUM_REQ*4-1:0] req_sel,
  input  logic [NUM_REQ-1:0]   req_we,
  input  logic [NUM_REQ*dw-1:0] req_wdata,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [NUM_REQ-1:0]   done,
  output logic [NUM_REQ-1:0]   err,
  output logic [dw-1:0]        rdata,
  output logic                 m_start,
  output logic [aw-1:0]        m_address,
  output logic [3:0]           m_selection,
  output logic                 m_write,
  output logic [dw-1:0]        m_data_wr,
  input  logic [dw-1:0]        m_data_rd,
  input  logic                 m_active,
  input  logic                 m_ack,
  input  logic                 m_err
);

  localparam int PW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, START, BUSY, DRAIN} state_t;

  state_t              state_reg, state_next;
  logic [NUM_REQ-1:0]  gnt_reg, gnt_next;
  logic [NUM_REQ-1:0]  done_reg, done_next;
  logic [NUM_REQ-1:0]  err_reg, err_next;
  logic [dw-1:0]       rdata_reg, rdata_next;
  logic                start_reg, start_next;
  logic [aw-1:0]       addr_reg, addr_next;
  logic [3:0]          sel_reg, sel_next;
  logic                we_reg, we_next;
  logic [dw-1:0]       wdata_reg, wdata_next;

  // Unpacked views of the packed request buses.
  logic [aw-1:0] addr_arr  [NUM_REQ];
  logic [3:0]    sel_arr   [NUM_REQ];
  logic [dw-1:0] wdata_arr [NUM_REQ];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign addr_arr[gi]  = req_addr[gi*aw +: aw];
      assign sel_arr[gi]   = req_sel[gi*4 +: 4];
      assign wdata_arr[gi] = req_wdata[gi*dw +: dw];
    end
  endgenerate

  logic          win_found;
  logic [PW-1:0] win_idx;

`ifdef WB_ARB_FIXED_PRIO_EN
  // Scan downwards so the lowest asserted index is the last one written.
  always_comb begin
    win_found = |req;
    win_idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[PW'(k)]) win_idx = PW'(k);
    end
  end
`else
  logic [PW-1:0] ptr_reg, ptr_next;

  // Search starts one past the previous winner and wraps, so the previous
  // winner is considered last.
  always_comb begin
    logic [PW-1:0] cand;
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = PW'((int'(ptr_reg) + k) % NUM_REQ);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end
`endif

  always_comb begin
    state_next = state_reg;
    gnt_next   = gnt_reg;
    done_next  = '0;
    err_next   = '0;
    start_next = 1'b0;
    rdata_next = rdata_reg;
    addr_next  = addr_reg;
    sel_next   = sel_reg;
    we_next    = we_reg;
    wdata_next = wdata_reg;
`ifndef WB_ARB_FIXED_PRIO_EN
    ptr_next   = ptr_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (win_found) begin
          gnt_next   = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx;
          addr_next  = addr_arr[win_idx];
          sel_next   = sel_arr[win_idx];
          we_next    = req_we[win_idx];
          wdata_next = wdata_arr[win_idx];
          // m_start is registered, so it is raised on entry to START.
          start_next = 1'b1;
`ifndef WB_ARB_FIXED_PRIO_EN
          ptr_next   = win_idx;
`endif
          state_next = START;
        end
      end
      START: state_next = BUSY;
      BUSY: begin
        // Error (or retry) takes precedence over a coincident ack.
        if (m_err) begin
          err_next   = gnt_reg;
          state_next = DRAIN;
        end else if (m_ack) begin
          done_next  = gnt_reg;
          if (!we_reg) rdata_next = m_data_rd;
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (!m_active) begin
          gnt_next   = '0;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_reg <= IDLE;
      gnt_reg   <= '0;
      done_reg  <= '0;
      err_reg   <= '0;
      start_reg <= 1'b0;
      rdata_reg <= '0;
      addr_reg  <= '0;
      sel_reg   <= '0;
      we_reg    <= 1'b0;
      wdata_reg <= '0;
`ifndef WB_ARB_FIXED_PRIO_EN
      ptr_reg   <= PW'(NUM_REQ - 1);
`endif
    end else begin
      state_reg <= state_next;
      gnt_reg   <= gnt_next;
      done_reg  <= done_next;
      err_reg   <= err_next;
      start_reg <= start_next;
      rdata_reg <= rdata_next;
      addr_reg  <= addr_next;
      sel_reg   <= sel_next;
      we_reg    <= we_next;
      wdata_reg <= wdata_next;
`ifndef WB_ARB_FIXED_PRIO_EN
      ptr_reg   <= ptr_next;
`endif
    end
  end

  assign gnt         = gnt_reg;
  assign done        = done_reg;
  assign err         = err_reg;
  assign rdata       = rdata_reg;
  assign m_start     = start_reg;
  assign m_address   = addr_reg;
  assign m_selection = sel_reg;
  assign m_write     = we_reg;
  assign m_data_wr   = wdata_reg;

endmodule
